// File: rtl/sobel_pkg.sv
// Shared types and defaults for the sobel frame sequencer.
// Holds the controller state enum and an index-width helper.
package sobel_pkg;

  localparam int unsigned DEF_WORD_SIZE = 8;
  localparam int unsigned DEF_ROW_SIZE  = 512;
  localparam int unsigned DEF_NUM_ROWS  = 512;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } ctrl_state_t;

  // Width of an index over n items, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_pos_counter.sv
// Raster row/col position counter with clear, enable and wrap.
// Ports: i_clock, i_reset (async low), i_clr, i_en -> o_row, o_sol, o_eol, o_sof, o_eof.
module frame_pos_counter
  import sobel_pkg::*;
#(
  parameter int unsigned ROW_SIZE = DEF_ROW_SIZE,
  parameter int unsigned NUM_ROWS = DEF_NUM_ROWS,
  localparam int unsigned CW = idx_w(ROW_SIZE),
  localparam int unsigned RW = idx_w(NUM_ROWS)
)(
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [RW-1:0] o_row,
  output logic          o_sol,
  output logic          o_eol,
  output logic          o_sof,
  output logic          o_eof
);

  localparam logic [CW-1:0] LAST_COL = CW'(ROW_SIZE - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_en) begin
      if (r_col == LAST_COL) begin
        r_col <= '0;
        if (r_row == LAST_ROW) begin
          r_row <= '0;
        end else begin
          r_row <= r_row + RW'(1);
        end
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  assign o_row = r_row;
  assign o_sol = (r_col == '0);
  assign o_eol = (r_col == LAST_COL);
  assign o_sof = o_sol && (r_row == '0);
  assign o_eof = o_eol && (r_row == LAST_ROW);

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer: feeds one frame into a free-running sobel core,
// drains its window latency with zeros and emits a framed, border-masked
// stream. Ports: i_clock, i_reset (async low), i_start, i_in_valid,
// i_in_pixel, o_in_ready, o_core_reset, o_core_pixel, i_core_result,
// o_out_valid/pixel/sof/eol/eof, o_busy, o_error (sticky), o_done.
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int unsigned WORD_SIZE = DEF_WORD_SIZE,
  parameter int unsigned ROW_SIZE = DEF_ROW_SIZE,
  parameter int unsigned NUM_ROWS = DEF_NUM_ROWS,
  parameter int unsigned CORE_LATENCY = ROW_SIZE + 3,
  parameter logic [WORD_SIZE-1:0] BORDER_VALUE = '0
)(
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [WORD_SIZE-1:0] i_in_pixel,
  output logic                 o_core_reset,
  output logic [WORD_SIZE-1:0] o_core_pixel,
  input  logic [WORD_SIZE-1:0] i_core_result,
  output logic                 o_out_valid,
  output logic [WORD_SIZE-1:0] o_out_pixel,
  output logic                 o_out_sof,
  output logic                 o_out_eol,
  output logic                 o_out_eof,
  output logic                 o_busy,
  output logic                 o_error,
  output logic                 o_done
);

  localparam int unsigned N   = ROW_SIZE * NUM_ROWS;
  localparam int unsigned FCW = idx_w(N + CORE_LATENCY);
  localparam int unsigned RW  = idx_w(NUM_ROWS);

  localparam logic [FCW-1:0] LAST_IN   = FCW'(N - 1);
  localparam logic [FCW-1:0] LAST_FEED = FCW'(N + CORE_LATENCY - 1);
  localparam logic [FCW-1:0] LAT       = FCW'(CORE_LATENCY);
  localparam logic [RW-1:0]  LAST_ROW  = RW'(NUM_ROWS - 1);

  ctrl_state_t r_state;
  ctrl_state_t w_next;

  logic [FCW-1:0]       r_feed_cnt;
  logic                 r_error;
  logic                 r_done;
  logic                 r_out_valid;
  logic [WORD_SIZE-1:0] r_out_pixel;
  logic                 r_out_sof;
  logic                 r_out_eol;
  logic                 r_out_eof;

  logic          w_feed;
  logic          w_sample;
  logic          w_border;
  logic [RW-1:0] w_row;
  logic          w_sol;
  logic          w_eol;
  logic          w_sof;
  logic          w_eof;

  always_comb begin
    w_next       = r_state;
    w_feed       = 1'b0;
    o_in_ready   = 1'b0;
    o_core_reset = 1'b0;
    o_core_pixel = '0;
    o_busy       = 1'b1;
    unique case (r_state)
      IDLE: begin
        o_core_reset = 1'b1;
        o_busy       = 1'b0;
        if (i_start) w_next = CLEAR;
      end
      CLEAR: begin
        o_core_reset = 1'b1;
        w_next       = RUN;
      end
      RUN: begin
        o_in_ready   = 1'b1;
        o_core_pixel = i_in_pixel;
        w_feed       = i_in_valid;
        // The core cannot stall, so a gap aborts the frame.
        if (!i_in_valid) begin
          w_next = IDLE;
        end else if (r_feed_cnt == LAST_IN) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        w_feed = 1'b1;
        if (r_feed_cnt == LAST_FEED) w_next = DONE;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next       = IDLE;
        o_core_reset = 1'b1;
        o_busy       = 1'b0;
      end
    endcase
  end

  // Core result for frame pixel k is valid at feed_cnt = k + latency.
  assign w_sample = w_feed && (r_feed_cnt >= LAT);

  assign w_border = (w_row == '0) || (w_row == LAST_ROW)
                    || w_sol || w_eol;

  frame_pos_counter #(
    .ROW_SIZE (ROW_SIZE),
    .NUM_ROWS (NUM_ROWS)
  ) u_pos (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clr   (r_state == CLEAR),
    .i_en    (w_sample),
    .o_row   (w_row),
    .o_sol   (w_sol),
    .o_eol   (w_eol),
    .o_sof   (w_sof),
    .o_eof   (w_eof)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_feed_cnt  <= '0;
      r_error     <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_pixel <= '0;
      r_out_sof   <= 1'b0;
      r_out_eol   <= 1'b0;
      r_out_eof   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == CLEAR) begin
        r_feed_cnt <= '0;
      end else if (w_feed && (r_feed_cnt != LAST_FEED)) begin
        r_feed_cnt <= r_feed_cnt + FCW'(1);
      end
      if ((r_state == IDLE) && i_start) begin
        r_error <= 1'b0;
      end else if ((r_state == RUN) && !i_in_valid) begin
        r_error <= 1'b1;
      end
      // Delayed so the pulse lands after the registered eof beat.
      r_done      <= (r_state == DONE);
      r_out_valid <= w_sample;
      r_out_sof   <= w_sample && w_sof;
      r_out_eol   <= w_sample && w_eol;
      r_out_eof   <= w_sample && w_eof;
      if (!w_sample) begin
        r_out_pixel <= '0;
      end else if (w_border) begin
        r_out_pixel <= BORDER_VALUE;
      end else begin
        r_out_pixel <= i_core_result;
      end
    end
  end

  assign o_error     = r_error;
  assign o_done      = r_done;
  assign o_out_valid = r_out_valid;
  assign o_out_pixel = r_out_pixel;
  assign o_out_sof   = r_out_sof;
  assign o_out_eol   = r_out_eol;
  assign o_out_eof   = r_out_eof;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Self-checking bench for sobel_frame_ctrl on an 8x6 frame.
// Behavioural core: 11-cycle delay line returning pixel+1.
module tb_sobel_frame_ctrl;

  localparam int ROW  = 8;
  localparam int ROWS = 6;
  localparam int LAT  = 11;
  localparam int N    = ROW * ROWS;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_pixel;
  logic       core_reset;
  logic [7:0] core_pixel;
  logic [7:0] core_result;
  logic       out_valid;
  logic [7:0] out_pixel;
  logic       out_sof;
  logic       out_eol;
  logic       out_eof;
  logic       busy;
  logic       error;
  logic       done;

  always #5 clk = ~clk;

  sobel_frame_ctrl #(
    .WORD_SIZE    (8),
    .ROW_SIZE     (ROW),
    .NUM_ROWS     (ROWS),
    .CORE_LATENCY (LAT),
    .BORDER_VALUE (8'd0)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_start       (start),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .i_in_pixel    (in_pixel),
    .o_core_reset  (core_reset),
    .o_core_pixel  (core_pixel),
    .i_core_result (core_result),
    .o_out_valid   (out_valid),
    .o_out_pixel   (out_pixel),
    .o_out_sof     (out_sof),
    .o_out_eol     (out_eol),
    .o_out_eof     (out_eof),
    .o_busy        (busy),
    .o_error       (error),
    .o_done        (done)
  );

  logic [7:0] dl [0:LAT-1];
  always @(posedge clk) begin
    if (core_reset) begin
      for (int i = 0; i < LAT; i++) dl[i] <= 8'd0;
    end else begin
      dl[0] <= core_pixel + 8'd1;
      for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
    end
  end
  assign core_result = dl[LAT-1];

  typedef struct {
    logic [7:0] pix;
    logic       sof;
    logic       eol;
    logic       eof;
    int         cyc;
  } orec_t;

  typedef struct {
    string name;
    int    gap;
    bit    pulse;
    bit    rnd;
    int    exp_outs;
    int    exp_err;
    int    exp_done;
  } scn_t;

  orec_t      oq[$];
  int         done_cycs[$];
  logic [7:0] px [N];
  int         cyc = 0;
  int         t0 = -1;
  int         stray = 0;
  int         drain_cyc = 0;
  int         drain_bad = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  scn_t       tbl [4];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (in_valid && in_ready && t0 < 0) t0 = cyc;
      if (out_valid) begin
        oq.push_back('{out_pixel, out_sof, out_eol, out_eof, cyc});
      end else if (out_sof || out_eol || out_eof) begin
        stray++;
      end
      if (done) done_cycs.push_back(cyc);
      if (t0 >= 0 && cyc >= t0 + N && cyc < t0 + N + LAT && busy) begin
        drain_cyc++;
        if (in_ready || core_pixel != 8'd0) drain_bad++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_pix(input int k);
    int r;
    int c;
    r = k / ROW;
    c = k % ROW;
    if (r == 0 || r == ROWS - 1 || c == 0 || c == ROW - 1) return 8'd0;
    return px[k] + 8'd1;
  endfunction

  task automatic fill_px(input bit rnd);
    for (int i = 0; i < N; i++) px[i] = rnd ? 8'($urandom) : 8'(i);
  endtask

  task automatic feed_frame(input int gap, input bit pulse);
    int w;
    oq.delete();
    done_cycs.delete();
    t0 = -1;
    stray = 0;
    drain_cyc = 0;
    drain_bad = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_clears_error", int'(error), 0);
    check("busy_after_start", int'(busy), 1);
    w = 0;
    while (!in_ready && w < 4) begin
      @(posedge clk); #1;
      w++;
    end
    check("run_entered", int'(in_ready), 1);
    for (int i = 0; i < N; i++) begin
      if (i == gap) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("uf_error", int'(error), 1);
        check("uf_busy", int'(busy), 0);
        check("uf_ready", int'(in_ready), 0);
        return;
      end
      in_valid = 1'b1;
      in_pixel = px[i];
      start = pulse && (i == 30);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit pulse);
    int w;
    w = 0;
    while (!done && w < 200) begin
      start = pulse && (w == 3);
      in_pixel = 8'($urandom);
      @(posedge clk); #1;
      w++;
    end
    start = 1'b0;
    check("done_seen", int'(done), 1);
  endtask

  task automatic check_frame(input int exp_outs, input int exp_done);
    int k;
    check("out_count", oq.size(), exp_outs);
    check("stray_flags", stray, 0);
    k = 0;
    while (k < oq.size() && k < exp_outs) begin
      check($sformatf("pix[%0d]", k), int'(oq[k].pix), int'(exp_pix(k)));
      check($sformatf("sof[%0d]", k), int'(oq[k].sof), int'(k == 0));
      check($sformatf("eol[%0d]", k), int'(oq[k].eol), int'(k % ROW == ROW - 1));
      check($sformatf("eof[%0d]", k), int'(oq[k].eof), int'(k == N - 1));
      check($sformatf("cyc[%0d]", k), oq[k].cyc, t0 + LAT + 1 + k);
      k++;
    end
    check("done_count", done_cycs.size(), exp_done);
    if (exp_done > 0) begin
      check("drain_cycles", drain_cyc, LAT);
      check("drain_bad", drain_bad, 0);
      if (oq.size() == N && done_cycs.size() > 0) begin
        check("done_after_eof", done_cycs[0], oq[N-1].cyc + 1);
      end
    end
  endtask

  initial begin
    int held;
    tbl[0] = '{"index",         -1, 1'b0, 1'b0, N, 0, 1};
    tbl[1] = '{"underrun",      20, 1'b0, 1'b0, 9, 1, 0};
    tbl[2] = '{"recover_rand",  -1, 1'b0, 1'b1, N, 0, 1};
    tbl[3] = '{"start_ignored", -1, 1'b1, 1'b1, N, 0, 1};

    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b1;
    in_pixel = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_core_reset", int'(core_reset), 1);
    check("rst_core_pixel", int'(core_pixel), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_pixel", int'(out_pixel), 0);
    check("rst_flags", int'({out_sof, out_eol, out_eof}), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_error", int'(error), 0);
    check("rst_done", int'(done), 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_in_ready", int'(in_ready), 0);
    check("idle_core_reset", int'(core_reset), 1);

    for (int s = 0; s < 4; s++) begin
      fill_px(tbl[s].rnd);
      feed_frame(tbl[s].gap, tbl[s].pulse);
      if (tbl[s].exp_done > 0) wait_done(tbl[s].pulse);
      repeat (30) @(posedge clk);
      #1;
      check({tbl[s].name, "_error"}, int'(error), tbl[s].exp_err);
      check({tbl[s].name, "_idle"}, int'(busy), 0);
      check_frame(tbl[s].exp_outs, tbl[s].exp_done);
    end

    fill_px(1'b1);
    feed_frame(-1, 1'b0);
    wait_done(1'b0);
    @(posedge clk); #1;
    check_frame(N, 1);
    feed_frame(-1, 1'b0);
    wait_done(1'b0);
    repeat (15) @(posedge clk);
    #1;
    check_frame(N, 1);

    fill_px(1'b0);
    feed_frame(-1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_valid", int'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_in_ready", int'(in_ready), 0);
    check("arst_core_reset", int'(core_reset), 1);
    check("arst_core_pixel", int'(core_pixel), 0);
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_out_pixel", int'(out_pixel), 0);
    check("arst_flags", int'({out_sof, out_eol, out_eof}), 0);
    check("arst_done", int'(done), 0);
    held = oq.size();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("arst_no_partial", oq.size(), held);
    check("arst_no_done", int'(done), 0);

    fill_px(1'b1);
    feed_frame(-1, 1'b0);
    wait_done(1'b0);
    repeat (15) @(posedge clk);
    #1;
    check_frame(N, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_frame_ctrl.md
Name: sobel_frame_ctrl

Overview:
Frame sequencer for the grayscale/sobel edge pipeline. It accepts one frame of pixels on a valid/ready stream and feeds them to the free-running sobel core, whose datapath has no enable. It drains the core's window latency with zero pixels and realigns the core result to frame coordinates. It emits a framed output stream with sof/eol/eof markers and border masking.

Parameters:
WORD_SIZE, 8, pixel width
ROW_SIZE, 512, pixels per row
NUM_ROWS, 512, rows per frame
CORE_LATENCY, ROW_SIZE+3, cycles from core_pixel presented to core_result for that pixel as window centre
BORDER_VALUE, 0, value forced on border output pixels

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  pulse; arms one frame when idle
in_valid  in  1  input pixel valid
in_ready  out  1  controller accepts in_pixel this cycle
in_pixel  in  WORD_SIZE  grayscale input pixel
core_reset  out  1  active-high synchronous clear to sobel core
core_pixel  out  WORD_SIZE  pixel driven into sobel core
core_result  in  WORD_SIZE  sobel core output
out_valid  out  1  out_pixel valid
out_pixel  out  WORD_SIZE  framed edge pixel
out_sof  out  1  first pixel of frame (with out_valid)
out_eol  out  1  last pixel of row (with out_valid)
out_eof  out  1  last pixel of frame (with out_valid)
busy  out  1  frame in progress
error  out  1  sticky: input underrun mid-frame
done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset (reset=0, async): state IDLE, all counters 0, in_ready=0, core_reset=1, core_pixel=0, out_valid/out_sof/out_eol/out_eof=0, out_pixel=0, busy=0, error=0, done=0.
- N = ROW_SIZE*NUM_ROWS. feed_cnt counts cycles the core is fed in a frame, 0..N+CORE_LATENCY-1.
- IDLE: core_reset=1, in_ready=0. start=1 -> CLEAR; error clears on that cycle.
- CLEAR: one cycle; core_reset=1, feed_cnt=0 -> RUN.
- RUN: core_reset=0, in_ready=1, core_pixel=in_pixel. in_valid=1 -> feed_cnt++. After pixel N-1 is accepted -> DRAIN.
- RUN with in_valid=0 is an underrun: error=1, -> IDLE, frame aborted, no further out_valid. The core has no stall, so gaps are not tolerated.
- DRAIN: in_ready=0, core_pixel=0, feed_cnt++ each cycle. When feed_cnt reaches N+CORE_LATENCY-1 -> DONE.
- DONE: done=1 for one cycle -> IDLE. busy=1 in CLEAR/RUN/DRAIN/DONE.
- start while busy: ignored.
- Output alignment: out_idx = feed_cnt - CORE_LATENCY, valid when feed_cnt >= CORE_LATENCY. On those cycles core_result is sampled and outputs are registered, so out_valid appears exactly 1 cycle later.
- Exactly N out_valid pulses per frame, contiguous, in raster order. The output row/col counters wrap col at ROW_SIZE-1 and row at NUM_ROWS-1.
- Border: out row 0, row NUM_ROWS-1, col 0 or col ROW_SIZE-1 -> out_pixel=BORDER_VALUE; otherwise out_pixel=core_result.
- out_sof at (0,0); out_eol at col ROW_SIZE-1; out_eof at (NUM_ROWS-1, ROW_SIZE-1), which is coincident with out_eol. All three are 0 when out_valid=0.
- done asserts the cycle after out_eof.
- Reset mid-frame: immediate return to reset values, core_reset=1, no partial output.
- Counter widths: $clog2(N+CORE_LATENCY) for feed_cnt, $clog2(ROW_SIZE) for col, $clog2(NUM_ROWS) for row. No overflow is permitted within a frame.

Decomposition:
- Package sobel_pkg: ctrl_state_t enum (IDLE, CLEAR, RUN, DRAIN, DONE), default WORD_SIZE/ROW_SIZE/NUM_ROWS constants.
- One sub-module: frame_pos_counter (row/col counter with enable, wrap, sol/eol/sof/eof flags). Instantiate it for the output coordinate side.

Test Plan:
Bench uses ROW_SIZE=8, NUM_ROWS=6, CORE_LATENCY=11, and a behavioural core model: a delay line of 11 cycles returning core_pixel+1, cleared by core_reset.
- Reset, then start, then 48 contiguous pixels value=index -> exactly 48 out_valid. Interior out_pixel equals model value; border = 0; out_sof on the 1st, out_eol every 8th, out_eof on the 48th; done the next cycle.
- Latency check: pixel 0 accepted at cycle T -> first out_valid at T+12; in_ready low for the 11 DRAIN cycles, core_pixel=0 throughout DRAIN.
- Underrun: drop in_valid at pixel 20 -> error=1 next cycle, state IDLE, busy=0, no more out_valid. A new start clears error and a full frame completes correctly.
- start pulsed during RUN and DRAIN -> ignored; output count stays 48 and only one done pulse.
- Async reset asserted mid-DRAIN -> all outputs at reset values without waiting for a clock edge; core_reset=1.
- Two back-to-back frames (start the cycle after done) -> second frame identical to first; out_sof occurs again with counters restarted at (0,0).
